// File: rtl/fir_pkg.sv
// Shared types and constants for the streaming FIR engine.
// Saturation is enabled by defining FIR_SATURATE_EN.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int PIPE_DEPTH = 4;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_tree.sv
// Registered tap products followed by a registered adder tree.
// Two pipeline stages from window to sum.
import fir_pkg::*;

module fir_tap_tree #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 5,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] win  [TAPS],
  input  logic signed [COEF_W-1:0] coef [TAPS],
  output logic signed [ACC_W-1:0]  sum
);

  localparam int PW = DATA_W + COEF_W;

  logic signed [PW-1:0]    prod [TAPS];
  logic signed [ACC_W-1:0] tree;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) prod[k] <= win[k] * coef[k];
    end
  end

  always_comb begin
    tree = '0;
    for (int k = 0; k < TAPS; k++)
      tree = tree + {{(ACC_W-PW){prod[k][PW-1]}}, prod[k]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum <= '0;
    else        sum <= tree;
  end

endmodule

// File: rtl/fir_stream_engine.sv
// Block-streaming N-tap FIR: reads port A, writes results on port B.
// Define FIR_SATURATE_EN for clamped output and the sat_count port.
import fir_pkg::*;

module fir_stream_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 5,
  parameter int ADDR_W = 10,
  parameter int SHIFT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W:0]           len,
  input  logic [ADDR_W-1:0]         src_base,
  input  logic [ADDR_W-1:0]         dst_base,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_idx,
  input  logic [COEF_W-1:0]         coef_data,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               cycle_count,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic                      mem_wr_en,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [DATA_W-1:0]         mem_wr_data
`ifdef FIR_SATURATE_EN
  ,
  output logic [15:0]               sat_count
`endif
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  state_t                  state;
  logic [ADDR_W:0]         len_q;
  logic [ADDR_W:0]         rd_cnt;
  logic [1:0]              drain_cnt;
  logic                    v1, v2, v3;
  logic                    start_acc;
  logic                    coef_ok;
  logic signed [DATA_W-1:0] win  [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  sum;

  assign start_acc = (state == IDLE) && start;
  assign coef_ok   = (state != RUN) && (state != DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      mem_rd_addr <= '0;
      len_q       <= '0;
      rd_cnt      <= '0;
      drain_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cycle_count <= '0;
            len_q       <= len;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              mem_rd_addr <= src_base;
              rd_cnt      <= (ADDR_W+1)'(1);
            end
          end
        end
        RUN: begin
          cycle_count <= cycle_count + 32'd1;
          if (rd_cnt == len_q) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
            rd_cnt      <= rd_cnt + (ADDR_W+1)'(1);
          end
        end
        DRAIN: begin
          cycle_count <= cycle_count + 32'd1;
          if (drain_cnt == 2'(PIPE_DEPTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // valid chain: read data, window, products, sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
    end else begin
      v1        <= (state == RUN);
      v2        <= v1;
      v3        <= v2;
      mem_wr_en <= v3;
      if (start_acc)      mem_wr_addr <= dst_base;
      else if (mem_wr_en) mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) win[k] <= '0;
    end else if (start_acc) begin
      for (int k = 0; k < TAPS; k++) win[k] <= '0;
    end else if (v1) begin
      win[0] <= mem_rd_data;
      for (int k = 1; k < TAPS; k++) win[k] <= win[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= COEF_W'(1);
    end else if (coef_we && coef_ok && (int'(coef_idx) < TAPS)) begin
      coef[coef_idx] <= coef_data;
    end
  end

  fir_tap_tree #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .ACC_W  (ACC_W)
  ) u_tree (
    .clk   (clk),
    .rst_n (rst_n),
    .win   (win),
    .coef  (coef),
    .sum   (sum)
  );

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SMAX =
    ACC_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  logic signed [ACC_W-1:0] shifted;
  logic                    sat_hit;

  always_comb begin
    shifted = sum >>> SHIFT;
    sat_hit = 1'b1;
    if (shifted > SMAX) begin
      mem_wr_data = SMAX[DATA_W-1:0];
    end else if (shifted < SMIN) begin
      mem_wr_data = SMIN[DATA_W-1:0];
    end else begin
      mem_wr_data = shifted[DATA_W-1:0];
      sat_hit     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (start_acc) begin
      sat_count <= '0;
    end else if (mem_wr_en && sat_hit && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign mem_wr_data = DATA_W'(sum >>> SHIFT);
`endif

endmodule

// File: tb/tb_fir_stream_engine.sv
// Scoreboard bench for fir_stream_engine with a behavioural dual-port RAM.
// Honours FIR_SATURATE_EN to pick the expected output arithmetic.
module tb_fir_stream_engine;

  localparam int TAPS  = 5;
  localparam int SHIFT = 2;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] len;
  logic [9:0]  src_base;
  logic [9:0]  dst_base;
  logic        coef_we;
  logic [2:0]  coef_idx;
  logic [7:0]  coef_data;
  logic        busy;
  logic        done;
  logic [31:0] cycle_count;
  logic [9:0]  mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [7:0]  mem_wr_data;
`ifdef FIR_SATURATE_EN
  logic [15:0] sat_count;
`endif

  logic signed [7:0] mem [1024];
  logic              poke_we;
  logic [9:0]        poke_addr;
  logic [7:0]        poke_data;

  wr_t q[$];
  wr_t mon_e;
  bit  mon_en;
  int  cm [TAPS];
  int  checks;
  int  errors;

  fir_stream_engine #(
    .DATA_W (8),
    .COEF_W (8),
    .TAPS   (TAPS),
    .ADDR_W (10),
    .SHIFT  (SHIFT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .src_base    (src_base),
    .dst_base    (dst_base),
    .coef_we     (coef_we),
    .coef_idx    (coef_idx),
    .coef_data   (coef_data),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
`ifdef FIR_SATURATE_EN
    ,
    .sat_count   (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_data <= mem[mem_rd_addr];
    if (poke_we)        mem[poke_addr] <= poke_data;
    else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en && mem_wr_en) begin
      if (q.size() == 0) begin
        chk("wr_unexp", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", int'(mem_wr_addr), mon_e.addr);
        chk("wr_data", int'($signed(mem_wr_data)), mon_e.data);
      end
    end
  end

  task automatic poke(input int a, input int d);
    @(negedge clk);
    poke_we   = 1'b1;
    poke_addr = 10'(a);
    poke_data = 8'(d);
    @(posedge clk);
    #1 poke_we = 1'b0;
  endtask

  task automatic set_coef(input int idx, input int val);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_idx  = 3'(idx);
    coef_data = 8'(val);
    @(posedge clk);
    #1 coef_we = 1'b0;
    cm[idx] = val;
  endtask

  task automatic run_block(input int src, input int dst,
                           input int ln, input bit disturb);
    int acc, y, k, wr_n, sat_exp;
    wr_t e;
    sat_exp = 0;
    for (int n = 0; n < ln; n++) begin
      acc = 0;
      for (int t = 0; t < TAPS; t++)
        if (n - t >= 0) acc += cm[t] * int'(mem[(src + n - t) % 1024]);
      y = acc >>> SHIFT;
`ifdef FIR_SATURATE_EN
      if (y > 127) begin
        y = 127;
        sat_exp++;
      end else if (y < -128) begin
        y = -128;
        sat_exp++;
      end
`else
      y = int'(byte'(y));
`endif
      e.addr = (dst + n) % 1024;
      e.data = y;
      q.push_back(e);
    end
    @(negedge clk);
    start    = 1'b1;
    len      = 11'(ln);
    src_base = 10'(src);
    dst_base = 10'(dst);
    @(posedge clk);
    #1 start = 1'b0;
    wr_n = 0;
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (mem_wr_en) wr_n++;
      if (k <= ln) chk("rd_addr", int'(mem_rd_addr), (src + k - 1) % 1024);
      if (ln > 0 && k == 2) chk("busy", int'(busy), 1);
      if (disturb && k == 3) begin
        start     = 1'b1;
        len       = 11'd3;
        src_base  = 10'd5;
        dst_base  = 10'd9;
        coef_we   = 1'b1;
        coef_idx  = 3'd0;
        coef_data = 8'(-7);
      end
      if (disturb && k == 4) begin
        start   = 1'b0;
        coef_we = 1'b0;
      end
      if (done) break;
    end
    chk("done_cyc", k, (ln == 0) ? 1 : ln + 5);
    chk("cyc_cnt", int'(cycle_count), (ln == 0) ? 0 : ln + 4);
    chk("wr_cnt", wr_n, ln);
    chk("sb_left", q.size(), 0);
`ifdef FIR_SATURATE_EN
    chk("sat_cnt", int'(sat_count), sat_exp);
`endif
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cyc"}, int'(cycle_count), 0);
    chk({tag, "_rda"}, int'(mem_rd_addr), 0);
    chk({tag, "_wen"}, int'(mem_wr_en), 0);
    chk({tag, "_wra"}, int'(mem_wr_addr), 0);
    chk({tag, "_wrd"}, int'(mem_wr_data), 0);
`ifdef FIR_SATURATE_EN
    chk({tag, "_sat"}, int'(sat_count), 0);
`endif
  endtask

  initial begin
    int imp [8];
    imp = '{16, 32, 48, 64, 80, 0, 0, 0};
    checks = 0;
    errors = 0;
    mon_en = 1'b1;
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    src_base = '0;
    dst_base = '0;
    coef_we = 1'b0;
    coef_idx = '0;
    coef_data = '0;
    poke_we = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    for (int i = 0; i < TAPS; i++) cm[i] = 1;
    repeat (3) @(negedge clk);
    chk_outs_zero("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) poke(100 + i, (i == 0) ? 64 : 0);
    for (int i = 0; i < TAPS; i++) set_coef(i, i + 1);
    run_block(100, 200, 8, 1'b0);
    for (int i = 0; i < 8; i++) chk("impulse", int'(mem[200 + i]), imp[i]);

    for (int i = 0; i < 16; i++) poke(300 + i, $urandom_range(0, 255));
    run_block(300, 400, 16, 1'b0);

    for (int i = 0; i < TAPS; i++) set_coef(i, 4);
    for (int i = 0; i < 5; i++) poke(500 + i, 64);
    run_block(500, 520, 5, 1'b0);
`ifdef FIR_SATURATE_EN
    chk("ovf_y4", int'(mem[524]), 127);
`else
    chk("ovf_y4", int'(mem[524]), 64);
`endif

    set_coef(0, 3);
    set_coef(1, -2);
    set_coef(2, 5);
    set_coef(3, 1);
    set_coef(4, -4);
    for (int i = 0; i < 16; i++) poke(800 + i, $urandom_range(0, 255));
    run_block(800, 850, 16, 1'b1);

    for (int i = 0; i < 8; i++) poke((1020 + i) % 1024, $urandom_range(0, 255));
    run_block(1020, 1020, 8, 1'b0);

    run_block(40, 60, 0, 1'b0);

    for (int i = 0; i < 16; i++) poke(600 + i, $urandom_range(0, 255));
    mon_en = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    len      = 11'd16;
    src_base = 10'd600;
    dst_base = 10'd650;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("wr_live", int'(mem_wr_en), 1);
    #2 rst_n = 1'b0;
    #1 chk_outs_zero("mid");
    q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < TAPS; i++) cm[i] = 1;
    run_block(600, 700, 16, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_stream_engine.md
# fir_stream_engine

Parametrised pipelined N-tap FIR engine. Streams a block of signed samples from a dual-port sample memory (port A read), filters them against a programmable coefficient bank, and writes the results back through port B at one sample per cycle. It succeeds the fixed 5-tap 8-bit filter pair inside `fir_top` and adds:
- configurable width, tap count and block placement;
- programmable coefficients;
- optional saturation.

## Interface
Parameters:
- `DATA_W`, 8, sample and result width (signed)
- `COEF_W`, 8, coefficient width (signed)
- `TAPS`, 5, number of taps (2..16)
- `ADDR_W`, 10, sample memory address width
- `SHIFT`, 2, arithmetic right shift applied to the accumulator
- `ACC_W` (localparam), `DATA_W+COEF_W+$clog2(TAPS)`, accumulator width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a block; sampled only in IDLE
- `len`  in  ADDR_W+1  number of samples, 0..2^ADDR_W
- `src_base`  in  ADDR_W  first input address
- `dst_base`  in  ADDR_W  first output address
- `coef_we`  in  1  coefficient write strobe
- `coef_idx`  in  $clog2(TAPS)  coefficient index (c0 multiplies the newest sample)
- `coef_data`  in  COEF_W  coefficient value
- `busy`  out  1  high from the cycle after the start is accepted until `done`
- `done`  out  1  one-cycle pulse at the end of a block
- `cycle_count`  out  32  cycles spent in RUN+DRAIN for the last block
- `mem_rd_addr`  out  ADDR_W  port A address
- `mem_rd_data`  in  DATA_W  port A data, registered read, valid 1 cycle after the address
- `mem_wr_en`  out  1  port B write enable
- `mem_wr_addr`  out  ADDR_W  port B address
- `mem_wr_data`  out  DATA_W  port B data
- `sat_count`  out  16  saturation events in the last block; present only with `FIR_SATURATE_EN`

## Operation
- Function: y[n] = (Σ_{k=0}^{TAPS-1} c_k·x[n−k]) >>> SHIFT.
  - x[n−k] for n−k<0 is 0; the window is cleared on every accepted start.
  - Arithmetic is signed and full precision to `ACC_W`.
  - No rounding; the shift truncates.
- States:
  - IDLE→RUN on `start` with `len`≠0. `len`, `src_base` and `dst_base` are latched on acceptance.
  - IDLE→DONE on `start` with `len`=0. No memory access occurs.
  - RUN issues read i at `src_base`+i for i=0..len−1, one per cycle. RUN→DRAIN after the last read.
  - DRAIN waits 4 cycles for the pipeline to empty, then →DONE.
  - DONE pulses `done` for one cycle, then →IDLE.
- Result n is written to `dst_base`+n.
- All address arithmetic wraps modulo 2^ADDR_W.
- In-place operation (src=dst) is legal. Reads lead writes by 4 addresses, so no input is overwritten before it is read.
- `start` while `busy` is ignored.
- `coef_we` while `busy` is ignored, so coefficients stay frozen during a block. In IDLE/DONE the write takes effect at the next edge.
- `cycle_count`:
  - cleared on start acceptance;
  - increments every RUN/DRAIN cycle;
  - holds its value after DONE.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - window and pipeline 0;
  - coefficients all 1 (moving-sum default).
- Start accepted at edge E0. Read i is issued in cycle i+1.
- Pipeline, counted from read issue in cycle t:
  - data valid t+1, shifted into the window at edge t+1;
  - products registered at edge t+2;
  - sum registered at edge t+3;
  - `mem_wr_en` high in cycle t+4.
- Block timing:
  - last write in cycle len+4;
  - `done` high in cycle len+5;
  - `cycle_count` = len+4;
  - throughput 1 sample/cycle.
- `len`=0: `done` in cycle 1, `cycle_count`=0, `mem_wr_en` never asserted.
- Reset mid-block: immediate return to IDLE. Any in-flight write is dropped and `mem_wr_en` is deasserted asynchronously.

## Configuration
- `FIR_SATURATE_EN` defined:
  - the shifted sum is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1];
  - `sat_count` increments, saturating at 0xFFFF, on each clamp;
  - `sat_count` is cleared on start acceptance.
- Undefined:
  - the low `DATA_W` bits of the shifted sum are written (two's-complement wrap);
  - the `sat_count` port does not exist.

## Structure
- Package `fir_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the `ACC_W` width function;
  - the pipeline depth constant (4).
- Sub-module `fir_tap_tree` takes the window and coefficients and produces the registered products and the registered adder-tree sum (2 stages).
- Control, address generation, the window shift register and the output shift/clamp stay in the top module.

## Test plan
- Impulse: x[0]=64, rest 0, coef {1,2,3,4,5}, len=8 → outputs 16,32,48,64,80,0,0,0 at dst..dst+7.
- Latency: len=16 → `done` 21 cycles after the start edge, `cycle_count`=20, exactly 16 `mem_wr_en` cycles.
- Overflow: x[0..4]=64, coef all 1, SHIFT=0 → y[4]=127 with `sat_count`≥1 when `FIR_SATURATE_EN` is defined; y[4]=64 (320 wrapped) without it.
- Wrap and in-place: src=dst=1020, len=8 → addresses 1020..1023,0..3 are read and written, and the results match a reference model on the original data.
- Ignored inputs: `start` pulse and `coef_we` during RUN → no restart, and the coefficients in use are unchanged.
- Boundary and reset: len=0 → `done` in cycle 1 with no writes. Then `rst_n` low mid-block → all outputs 0, and the next start behaves as if from reset (coefficients back to all 1).
